// File: rtl/fir_fold_ctrl.sv
// rtl/fir_fold_ctrl.sv - sequencer for a folded symmetric FIR (one pre-adder, one MAC)
module fir_fold_ctrl #(
  parameter int TAP     = 101,
  parameter int ADDR_W  = 7,
  parameter int COEF_W  = 6,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_zero,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              centre,
  output logic [COEF_W-1:0] coef_addr,
  output logic              mac_first,
  output logic              mac_en,
  output logic              acc_done,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int HALF    = (TAP + 1) / 2;
  localparam int DRAIN_N = RD_LAT + MAC_LAT;

  // S_RST is the one-cycle holding state after reset release; all outputs stay 0 there
  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(TAP - 1);
  localparam logic [COEF_W-1:0] K_LAST   = COEF_W'(HALF - 1);
  localparam logic [3:0]        DRN_LAST = 4'(DRAIN_N - 1);

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] newest_q, newest_d;
  logic [COEF_W-1:0] k_q,      k_d;
  logic [3:0]        drn_q,    drn_d;
  logic              ovr_q,    ovr_d;

  logic              accept;
  logic [ADDR_W-1:0] k_ext;

  assign accept  = in_valid & in_ready;
  assign k_ext   = ADDR_W'(k_q);
  assign overrun = ovr_q;

  // Sequencer next state; the clear sweep reuses wr_ptr as its address counter so it exits at 0
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    newest_d = newest_q;
    k_d      = k_q;
    drn_d    = drn_q;
    case (state_q)
      S_RST: begin
        state_d  = S_CLEAR;
        wr_ptr_d = '0;
      end
      S_CLEAR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == PTR_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          newest_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = S_IDLE;
        else                   drn_d   = drn_q + 1'b1;
      end
      default: state_d = S_RST;
    endcase
  end

  // Sticky overrun; a new offer while not ready beats a simultaneous clear
  always_comb begin
    ovr_d = (in_valid & ~in_ready) | (ovr_q & ~ovr_clr);
  end

  // Strobes and addresses decoded from the current state; pair addresses wrap modulo the buffer
  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    wr_addr   = '0;
    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    centre    = 1'b0;
    coef_addr = '0;
    mac_first = 1'b0;
    mac_en    = 1'b0;
    acc_done  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        wr_addr = wr_ptr_q;
        busy    = 1'b1;
      end
      S_IDLE: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_addr  = wr_ptr_q;
      end
      S_RUN: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        mac_en    = 1'b1;
        rd_addr_a = newest_q - k_ext;
        rd_addr_b = newest_q - SPAN + k_ext;
        coef_addr = k_q;
        mac_first = (k_q == '0);
        centre    = (k_q == K_LAST);
      end
      S_DRAIN: begin
        busy     = 1'b1;
        acc_done = (drn_q == DRN_LAST);
      end
      default: ;
    endcase
  end

  // State registers; reset aborts any sample in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RST;
      wr_ptr_q <= '0;
      newest_q <= '0;
      k_q      <= '0;
      drn_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      newest_q <= newest_d;
      k_q      <= k_d;
      drn_q    <= drn_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// tb/tb_fir_fold_ctrl.sv - self-checking bench for fir_fold_ctrl
module tb_fir_fold_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       in_ready, wr_en, wr_zero, rd_en, centre, mac_first, mac_en, acc_done, busy, overrun;
  logic [6:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [5:0] coef_addr;

  int checks = 0;
  int errors = 0;

  fir_fold_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .centre(centre), .coef_addr(coef_addr), .mac_first(mac_first),
    .mac_en(mac_en), .acc_done(acc_done), .busy(busy),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  logic [36:0] dut_vec;
  logic [36:0] exp_vec;
  assign dut_vec = {in_ready, wr_en, wr_zero, wr_addr, rd_en, rd_addr_a, rd_addr_b,
                    centre, coef_addr, mac_first, mac_en, acc_done, busy, overrun};

  // Reference model: phase given by clear progress and cycles elapsed since the last accept
  logic m_inrst, m_hold, m_ovr, e_rdy;
  int   m_clr, m_since, m_wp, m_new;

  function automatic int mod128(input int v);
    return ((v % 128) + 128) % 128;
  endfunction

  function automatic void model_reset();
    m_inrst = 1'b0; m_hold = 1'b1; m_ovr = 1'b0;
    m_clr = 0; m_since = -1; m_wp = 0; m_new = 0;
  endfunction

  function automatic void model_eval();
    logic wen, wz, ren, cen, first, men, done, bsy;
    int   wa, ra, rb, k;
    e_rdy = 0; wen = 0; wz = 0; ren = 0; cen = 0; first = 0; men = 0; done = 0; bsy = 0;
    wa = 0; ra = 0; rb = 0; k = 0;
    if (!m_inrst && !m_hold) begin
      if (m_clr < 128) begin
        wen = 1; wz = 1; wa = m_clr; bsy = 1;
      end else if (m_since < 0) begin
        e_rdy = 1; wen = in_valid; wa = m_wp;
      end else if (m_since <= 51) begin
        k = m_since - 1;
        bsy = 1; ren = 1; men = 1;
        ra = mod128(m_new - k);
        rb = mod128(m_new - 100 + k);
        first = (k == 0); cen = (k == 50);
      end else begin
        bsy = 1; done = (m_since == 54);
      end
    end
    exp_vec = {e_rdy, wen, wz, 7'(wa), ren, 7'(ra), 7'(rb), cen, 6'(k),
               first, men, done, bsy, (m_inrst ? 1'b0 : m_ovr)};
  endfunction

  function automatic void model_advance();
    if (m_inrst) return;
    m_ovr = (in_valid && !e_rdy) || (m_ovr && !ovr_clr);
    if (m_hold) begin
      m_hold = 0; m_clr = 0;
    end else if (m_clr < 128) begin
      m_clr++;
    end else if (m_since < 0) begin
      if (in_valid) begin
        m_new = m_wp; m_wp = (m_wp + 1) % 128; m_since = 1;
      end
    end else begin
      m_since++;
      if (m_since == 55) m_since = -1;
    end
  endfunction

  task automatic drive(input logic v, input logic c);
    model_advance();
    @(posedge clk);
    #1;
    in_valid = v;
    ovr_clr  = c;
    model_eval();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; ovr_clr = 0; m_inrst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_vec !== 37'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", dut_vec); end
    @(posedge clk);
    #1 rst = 0;
    model_reset(); model_eval();
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_hold got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 128; i++) begin
      drive(0, 0);
      checks++;
      if ({in_ready, wr_en, wr_zero, wr_addr, overrun} !== {1'b0, 1'b1, 1'b1, 7'(i), 1'b0}) begin
        errors++; $display("FAIL clear_sweep i=%0d got rdy=%b we=%b wz=%b wa=%0d ovr=%b", i, in_ready, wr_en, wr_zero, wr_addr, overrun);
      end
    end
    drive(0, 0);
    checks++;
    if ({in_ready, wr_en, busy, overrun} !== 4'b1000) begin
      errors++; $display("FAIL clear_exit got rdy=%b we=%b busy=%b ovr=%b want 1 0 0 0", in_ready, wr_en, busy, overrun);
    end
  endtask

  task automatic test_first_sample();
    int acc_t, nfirst, ncen;
    acc_t = -1; nfirst = 0; ncen = 0;
    drive(1, 0);
    checks++;
    if ({in_ready, wr_en, wr_addr} !== {1'b1, 1'b1, 7'd0}) begin
      errors++; $display("FAIL accept0 got rdy=%b we=%b wa=%0d want 1 1 0", in_ready, wr_en, wr_addr);
    end
    for (int t = 1; t <= 55; t++) begin
      drive(0, 0);
      if (mac_first) nfirst++;
      if (centre) ncen++;
      if (acc_done) acc_t = (acc_t < 0) ? t : 1000;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL first_step t=%0d got %h want %h", t, dut_vec, exp_vec); end
      if (t == 1) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, coef_addr, mac_first, centre} !== {7'd0, 7'd28, 6'd0, 1'b1, 1'b0}) begin
          errors++; $display("FAIL k0_addr got a=%0d b=%0d k=%0d first=%b want 0 28 0 1", rd_addr_a, rd_addr_b, coef_addr, mac_first);
        end
      end
      if (t == 51) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, coef_addr, mac_first, centre} !== {7'd78, 7'd78, 6'd50, 1'b0, 1'b1}) begin
          errors++; $display("FAIL centre_addr got a=%0d b=%0d k=%0d c=%b want 78 78 50 1", rd_addr_a, rd_addr_b, coef_addr, centre);
        end
      end
    end
    checks++;
    if (acc_t != 54) begin errors++; $display("FAIL acc_latency got %0d want 54", acc_t); end
    checks++;
    if (nfirst != 1 || ncen != 1) begin errors++; $display("FAIL strobe_counts got first=%0d centre=%0d want 1 1", nfirst, ncen); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_at_55 got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    for (int s = 2; s <= 129; s++) begin
      drive(1, 0);
      checks++;
      if ({in_ready, wr_en, wr_addr} !== {1'b1, 1'b1, 7'((s - 1) % 128)}) begin
        errors++; $display("FAIL wrap_accept s=%0d got rdy=%b we=%b wa=%0d want wa=%0d", s, in_ready, wr_en, wr_addr, (s - 1) % 128);
      end
      for (int j = 0; j < 55; j++) begin
        drive(0, 0);
        if (s == 129 && j == 0) begin
          checks++;
          if ({rd_addr_a, rd_addr_b, mac_first} !== {7'd0, 7'd28, 1'b1}) begin
            errors++; $display("FAIL wrap_k0 got a=%0d b=%0d first=%b want 0 28 1", rd_addr_a, rd_addr_b, mac_first);
          end
        end
      end
    end
  endtask

  task automatic test_held_valid();
    int last, n_acc, first_nr;
    last = -1; n_acc = 0; first_nr = -1;
    for (int c = 0; c < 200; c++) begin
      drive(1, 0);
      if (in_ready && in_valid) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 55) begin errors++; $display("FAIL accept_spacing got %0d want 55", c - last); end
        end
        last = c; n_acc++;
      end
      if (!in_ready && first_nr < 0) begin
        first_nr = c;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", overrun); end
      end else if (first_nr >= 0 && c == first_nr + 1) begin
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
      end
    end
    checks++;
    if (n_acc != 4) begin errors++; $display("FAIL held_accepts got %0d want 4", n_acc); end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    drive(0, 0);
    while (!in_ready && n < 80) begin drive(0, 0); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_timeout got rdy=%b want 1", tag, in_ready); end
  endtask

  task automatic test_ovr_same_cycle();
    wait_idle("ovr");
    drive(1, 0);
    drive(1, 1);
    drive(0, 0);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
    wait_idle("ovr2");
    drive(0, 1);
    drive(0, 0);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_random();
    int nfail;
    nfail = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 99) < 30), logic'($urandom_range(0, 99) < 8));
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; nfail++;
        if (nfail <= 10) $display("FAIL random i=%0d got %h want %h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_midrun_reset();
    int ndone;
    ndone = 0;
    wait_idle("mid");
    drive(1, 0);
    for (int i = 0; i < 21; i++) drive(0, 0);
    checks++;
    if ({mac_en, coef_addr} !== {1'b1, 6'd20}) begin
      errors++; $display("FAIL mid_k20 got en=%b k=%0d want 1 20", mac_en, coef_addr);
    end
    #1 rst = 1; m_inrst = 1; model_eval();
    #1;
    checks++;
    if (dut_vec !== 37'd0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", dut_vec); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (acc_done) ndone++;
    end
    @(posedge clk);
    #1 rst = 0; in_valid = 0; ovr_clr = 0;
    model_reset(); model_eval();
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      drive(0, 0);
      if (acc_done) ndone++;
      checks++;
      if (dut_vec !== exp_vec || wr_addr !== 7'(i) || wr_zero !== 1'b1) begin
        errors++; $display("FAIL mid_clear i=%0d got %h want %h", i, dut_vec, exp_vec);
      end
    end
    drive(0, 0);
    checks++;
    if (in_ready !== 1'b1 || ndone != 0) begin
      errors++; $display("FAIL mid_recover got rdy=%b done_count=%0d want 1 0", in_ready, ndone);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_first_sample();
    test_wrap();
    test_held_valid();
    test_ovr_same_cycle();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_fold_ctrl.md
Name: fir_fold_ctrl

Overview:
- Sequencer for a folded (time-shared) symmetric 101-tap FIR.
- Replaces the fully parallel 51-multiplier tree with one pre-adder and one MAC.
- Owns the circular sample-buffer write/read addressing, coefficient addressing, MAC control strobes and the sample-rate accept handshake.
- Sits between the audio sample source and the shared buffer RAM, coefficient ROM, pre-adder and MAC.

Parameters:
- TAP, 101, filter length; must be odd.
- HALF, (TAP+1)/2 = 51, folded MAC steps per sample; pairs 0..HALF-2, centre tap HALF-1.
- ADDR_W, 7, sample buffer address width; 2^ADDR_W must be >= TAP.
- COEF_W, 6, coefficient address width.
- RD_LAT, 1, buffer RAM read latency in cycles.
- MAC_LAT, 2, pre-adder plus MAC latency in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  new input sample present.
- in_ready  out  1  controller can accept a sample.
- wr_en  out  1  buffer write strobe.
- wr_zero  out  1  force write data to 0 (clear sweep).
- wr_addr  out  ADDR_W  buffer write address.
- rd_en  out  1  buffer read strobe.
- rd_addr_a  out  ADDR_W  newer sample of the pair.
- rd_addr_b  out  ADDR_W  older sample of the pair.
- centre  out  1  current step is the centre tap; pre-adder uses a only, b forced to 0.
- coef_addr  out  COEF_W  coefficient index k.
- mac_first  out  1  first step; MAC loads the product instead of accumulating.
- mac_en  out  1  step valid; aligned with rd_addr.
- acc_done  out  1  one-cycle strobe: accumulator holds a finished output.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: a sample was offered while in_ready=0.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset values:
  - All outputs 0.
  - wr_ptr=0, k=0, newest=0.
  - State = CLEAR on the first edge after rst deasserts.
  - rst mid-operation aborts immediately; no acc_done is issued for the aborted sample.
- CLEAR:
  - wr_en=1, wr_zero=1, in_ready=0.
  - wr_addr sweeps 0..2^ADDR_W-1, one location per cycle (128 cycles), then IDLE.
  - wr_ptr is 0 on exit.
- IDLE:
  - in_ready=1.
  - wr_en = in_valid (combinational), wr_addr=wr_ptr, wr_zero=0.
  - On accept: newest<=wr_ptr, wr_ptr<=wr_ptr+1 (mod 2^ADDR_W), k<=0, go to RUN.
- RUN, one step per cycle for k = 0..HALF-1:
  - rd_en=1, mac_en=1.
  - rd_addr_a = newest-k (mod 2^ADDR_W).
  - rd_addr_b = newest-(TAP-1)+k (mod 2^ADDR_W).
  - coef_addr=k.
  - mac_first=(k==0).
  - centre=(k==HALF-1); at the centre step rd_addr_a == rd_addr_b.
  - After k=HALF-1, go to DRAIN.
- DRAIN:
  - Counts RD_LAT+MAC_LAT cycles with no read or MAC strobes.
  - acc_done pulses on the last DRAIN cycle, then IDLE.
  - acc_done is asserted RD_LAT+MAC_LAT cycles after the cycle carrying the centre step.
- Timing:
  - Sample accepted at cycle 0; RUN occupies cycles 1..51; acc_done at cycle 51+RD_LAT+MAC_LAT = 54 with defaults.
  - Next accept possible at cycle 55.
- Handshake:
  - in_ready is high only in IDLE; a sample is taken only when in_valid & in_ready.
  - in_valid held across cycles is accepted exactly once per IDLE entry.
- Overrun:
  - Set when in_valid=1 and in_ready=0, in any state including CLEAR.
  - ovr_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: all buffer addresses are modulo 2^ADDR_W; wr_ptr wraps 127->0 with no bubble.
- Arithmetic: address subtraction is ADDR_W-bit unsigned wrap; no saturation.
- Buffer contents: zeros written in CLEAR make the first TAP-1 outputs use zero history.

Test Plan:
- Reset release, then idle -> 128 cycles of wr_en=1 and wr_zero=1 with wr_addr 0..127; in_ready rises at cycle 128; overrun=0.
- First sample accepted with wr_ptr=0:
  - k=0: rd_a=0, rd_b=28.
  - k=50: rd_a=78, rd_b=78, centre=1.
  - mac_first only at k=0; acc_done 54 cycles after accept.
- Accept 128 consecutive samples, then a 129th -> 129th wr_addr=0 (wrap); its k=0 step gives rd_a=0, rd_b=28.
- in_valid held high continuously -> accepts spaced exactly 55 cycles apart; overrun set on the first cycle in_valid=1 with in_ready=0.
- ovr_clr and a new overrun in the same cycle -> overrun stays 1; ovr_clr alone in IDLE -> 0.
- rst asserted at RUN k=20 -> all outputs 0 at once, no acc_done; after release the full CLEAR sweep repeats.
